// File: rtl/uart_rx.sv
// uart_rx - oversampling UART receiver, 8 data bits, LSB first, 1 stop bit.
//
// The line is sampled once per bit at mid-bit, timed from the falling edge of
// the start bit. A received byte is offered on rx_data/rx_valid and handed
// over on any clk edge where rx_valid and rx_ready are both high.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (legal 4..65535, default 434)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   serial       asynchronous UART line, idle high
//   rx_data      last accepted byte, stable while rx_valid is high
//   rx_valid     rx_data holds a byte not yet taken by the consumer
//   rx_ready     consumer takes the byte on an edge with rx_valid high
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: byte completed while the previous one was
//                still waiting and not taken in that cycle
//   parity_err   one-cycle pulse: even-parity mismatch (0 without parity)
//
// Build option
//   UART_RX_PARITY_EN  when defined, one even-parity bit follows the data
//                      bits; a mismatching frame is discarded.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
  // Start bit is checked half a bit in; all later samples are one bit apart.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Bit value that makes the total count of ones in data+parity even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [1:0]       sync_r;
  logic             rxs_s;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       shift_r, shift_s;
  logic             accept_r, accept_s;
  logic             ferr_pend_r, ferr_pend_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_r, par_bad_s;
  logic             perr_pend_r, perr_pend_s;
`endif

  assign rxs_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], serial};
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      accept_r    <= 1'b0;
      ferr_pend_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r   <= 1'b0;
      perr_pend_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      accept_r    <= accept_s;
      ferr_pend_r <= ferr_pend_s;
`ifdef UART_RX_PARITY_EN
      par_bad_r   <= par_bad_s;
      perr_pend_r <= perr_pend_s;
`endif
    end
  end

  // Next-state logic. The bit counter is cleared at every sample point so
  // each bit is timed from the previous sample and never drifts.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    accept_s    = 1'b0;
    ferr_pend_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_s   = par_bad_r;
    perr_pend_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        cnt_s     = '0;
        bit_cnt_s = 3'd0;
        if (!rxs_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = '0;
          // Line back high at mid start bit: treat as a glitch.
          if (!rxs_s) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == LAST) begin
          cnt_s     = '0;
          shift_s   = {rxs_s, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_r == LAST) begin
          cnt_s     = '0;
          par_bad_s = even_parity(shift_r) ^ rxs_s;
          state_s   = STOP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_r == LAST) begin
          cnt_s = '0;
`ifdef UART_RX_PARITY_EN
          perr_pend_s = par_bad_r;
`endif
          if (rxs_s) begin
`ifdef UART_RX_PARITY_EN
            accept_s = ~par_bad_r;
`else
            accept_s = 1'b1;
`endif
            state_s  = IDLE;
          end else begin
            ferr_pend_s = 1'b1;
            state_s     = WAIT_HIGH;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        // A break or stuck-low line reports once, then waits for idle.
        cnt_s = '0;
        if (rxs_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_HIGH;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_s     = '0;
        bit_cnt_s = 3'd0;
      end
    endcase
  end

  // Output stage: hand-off register and one-cycle error pulses, updated on
  // the edge after the stop-bit sample. shift_r is not touched again until
  // the next frame's data bits, so it is still valid here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr_pend_r;
      overrun_err <= 1'b0;
      if (accept_r) begin
        if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse, aligned with the other frame outcomes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_pend_r;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Posedges from driving the start bit until rx_valid is seen high:
  // 2 synchronizer edges + detect edge, half bit, (NBITS-1) full bits, +1.
  localparam int LAT = 3 + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int vectors = 0;
  int miscompares = 0;

  // Monitor totals (written only by the monitor).
  int         valid_cyc = 0;
  int         ferr_cnt = 0;
  int         oerr_cnt = 0;
  int         perr_cnt = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .serial(serial),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );

  // Observe outputs mid-cycle; a transfer happens at the next posedge when
  // rx_valid and rx_ready are both high here.
  always @(negedge clk) begin
    #1;
    if (rx_valid === 1'b1) valid_cyc++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun_err === 1'b1) oerr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame starting at the current negedge; ends on a negedge with
  // the line left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    serial = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) serial = 1'b1;
`endif
    serial = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle(3);
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    vectors++;
    if ({rx_valid, frame_err, overrun_err, parity_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000",
               {rx_valid, frame_err, overrun_err, parity_err});
    end
    reset = 1'b1;
    idle(10);
    vectors++;
    if ({rx_valid, frame_err, overrun_err, parity_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {rx_valid, frame_err, overrun_err, parity_err});
    end
  endtask

  task automatic test_single_frame;
    int v0, g0, f0, o0, k;
    v0 = valid_cyc; g0 = got_q.size(); f0 = ferr_cnt; o0 = oerr_cnt;
    rx_ready = 1'b1;
    k = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (rx_valid !== 1'b1 && k < 400) begin
          @(posedge clk);
          #1;
          k++;
        end
      end
    join
    idle(20);
    vectors++;
    if (k != LAT) begin
      miscompares++;
      $display("FAIL latency: got %0d edges expected %0d", k, LAT);
    end
    vectors++;
    if (valid_cyc - v0 != 1) begin
      miscompares++;
      $display("FAIL a5_valid_cycles: got %0d expected 1", valid_cyc - v0);
    end
    vectors++;
    if (got_q.size() != g0 + 1 || got_q[got_q.size()-1] !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_data: got %0d bytes last %h expected 1 byte a5",
               got_q.size() - g0, got_q.size() > 0 ? got_q[got_q.size()-1] : 8'hxx);
    end
    vectors++;
    if (ferr_cnt != f0 || oerr_cnt != o0) begin
      miscompares++;
      $display("FAIL a5_errors: frame %0d overrun %0d expected 0 0",
               ferr_cnt - f0, oerr_cnt - o0);
    end
  endtask

  task automatic test_glitch(input int len);
    int v0, f0, o0;
    v0 = valid_cyc; f0 = ferr_cnt; o0 = oerr_cnt;
    serial = 1'b0;
    idle(len);
    serial = 1'b1;
    idle(40);
    vectors++;
    if (valid_cyc != v0 || ferr_cnt != f0 || oerr_cnt != o0) begin
      miscompares++;
      $display("FAIL glitch_%0d: valid %0d frame %0d overrun %0d expected 0 0 0",
               len, valid_cyc - v0, ferr_cnt - f0, oerr_cnt - o0);
    end
  endtask

  task automatic test_frame_err;
    int v0, g0, f0;
    v0 = valid_cyc; g0 = got_q.size(); f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(100);
    serial = 1'b1;
    idle(20);
    vectors++;
    if (ferr_cnt - f0 != 1) begin
      miscompares++;
      $display("FAIL frame_err_count: got %0d expected 1", ferr_cnt - f0);
    end
    vectors++;
    if (valid_cyc != v0) begin
      miscompares++;
      $display("FAIL frame_err_no_valid: got %0d valid cycles expected 0", valid_cyc - v0);
    end
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    vectors++;
    if (got_q.size() != g0 + 1 || got_q[got_q.size()-1] !== 8'h55 || ferr_cnt - f0 != 1) begin
      miscompares++;
      $display("FAIL after_frame_err: got %0d bytes frame %0d expected 1 byte 55 frame 1",
               got_q.size() - g0, ferr_cnt - f0);
    end
  endtask

  task automatic test_overrun;
    int o0, g0;
    o0 = oerr_cnt; g0 = got_q.size();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(20);
    vectors++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_hold: got valid %b data %h expected 1 11", rx_valid, rx_data);
    end
    vectors++;
    if (oerr_cnt - o0 != 1) begin
      miscompares++;
      $display("FAIL overrun_count: got %0d expected 1", oerr_cnt - o0);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    idle(3);
    vectors++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_drain: got valid %b data %h expected 0 11", rx_valid, rx_data);
    end
    vectors++;
    if (got_q.size() != g0 + 1 || got_q[got_q.size()-1] !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_transfer: got %0d bytes expected 1 byte 11", got_q.size() - g0);
    end
    rx_ready = 1'b1;
  endtask

  task automatic test_reset_midframe;
    int v0, g0;
    logic [11:0] during;
    v0 = valid_cyc; g0 = got_q.size();
    during = 12'hfff;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        idle(CPB * 5 + CPB / 2);
        reset = 1'b0;
        idle(3);
        during = {rx_data, rx_valid, frame_err, overrun_err, parity_err};
        reset = 1'b1;
      end
    join
    idle(20);
    vectors++;
    if (during !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h expected 000", during);
    end
    vectors++;
    if (valid_cyc != v0) begin
      miscompares++;
      $display("FAIL reset_mid_no_valid: got %0d valid cycles expected 0", valid_cyc - v0);
    end
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    vectors++;
    if (got_q.size() != g0 + 1 || got_q[got_q.size()-1] !== 8'h81) begin
      miscompares++;
      $display("FAIL after_reset_frame: got %0d bytes expected 1 byte 81", got_q.size() - g0);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int g0, f0, o0;
    g0 = got_q.size(); f0 = ferr_cnt; o0 = oerr_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
    end
    idle(20);
    vectors++;
    if (got_q.size() - g0 != n) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d bytes expected %0d", got_q.size() - g0, n);
    end
    for (int i = 0; i < n; i++) begin
      if (g0 + i < got_q.size()) begin
        vectors++;
        if (got_q[g0+i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[g0+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (ferr_cnt != f0 || oerr_cnt != o0) begin
      miscompares++;
      $display("FAIL b2b_errors: frame %0d overrun %0d expected 0 0",
               ferr_cnt - f0, oerr_cnt - o0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, g0, p0;
    g0 = got_q.size(); p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    vectors++;
    if (got_q.size() != g0 + 1 || got_q[got_q.size()-1] !== 8'h07 || perr_cnt != p0) begin
      miscompares++;
      $display("FAIL parity_good: got %0d bytes perr %0d expected 1 byte 07 perr 0",
               got_q.size() - g0, perr_cnt - p0);
    end
    v0 = valid_cyc;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    vectors++;
    if (perr_cnt - p0 != 1 || valid_cyc != v0) begin
      miscompares++;
      $display("FAIL parity_bad: got perr %0d valid %0d expected 1 0",
               perr_cnt - p0, valid_cyc - v0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_glitch(5);
    test_glitch($urandom_range(1, 7));
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back(8);
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
